// File: rtl/sprite_record_tx.sv
// -----------------------------------------------------------------------------
// sprite_record_tx
//
// Serialises one sprite record (id, x, y, scale) into six bytes presented on
// enqueue_data/enqueue_en. Each byte lasts one data_clk period: CLK_DIV cycles
// with data_clk low, then CLK_DIV cycles with data_clk high. The receiver
// samples on the rising edge of data_clk. Byte order: id, x[15:8], x[7:0],
// y[15:8], y[7:0], scale.
//
// Optional feature (compile-time macro SPRITE_TX_RESYNC_EN): every record is
// preceded by one sync period (SYNC_LOW, SYNC_HIGH) with enqueue_en = 0 and
// enqueue_data = 0. The receiver uses it to clear its byte index.
//
// Parameters
//   CLK_DIV       clock cycles per data_clk half-period (1..255)
// Ports
//   clock         system clock, rising edge
//   resetn        asynchronous active-low reset
//   rec_valid     record offered
//   rec_ready     high only in IDLE; accept = rec_valid && rec_ready
//   rec_id/x/y/scale  record fields, captured on accept
//   data_clk      byte strobe
//   enqueue_en    high while a record byte is presented
//   enqueue_data  current byte
//   busy          high in any state other than IDLE
//   records_sent  count of completed records (wraps at 16 bits)
// -----------------------------------------------------------------------------
module sprite_record_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [7:0]  rec_id,
  input  logic [15:0] rec_x,
  input  logic [15:0] rec_y,
  input  logic [7:0]  rec_scale,
  output logic        data_clk,
  output logic        enqueue_en,
  output logic [7:0]  enqueue_data,
  output logic        busy,
  output logic [15:0] records_sent
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOW       = 3'd1,
    HIGH      = 3'd2
`ifdef SPRITE_TX_RESYNC_EN
    ,
    SYNC_LOW  = 3'd3,
    SYNC_HIGH = 3'd4
`endif
  } state_e;

  // Field order matches the wire order, so byte i is simply slice i from the top.
  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
  } rec_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BYTE  = 3'd5;

  function automatic logic [7:0] byte_sel(input rec_t r, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = r.id;
      3'd1:    b = r.x[15:8];
      3'd2:    b = r.x[7:0];
      3'd3:    b = r.y[15:8];
      3'd4:    b = r.y[7:0];
      default: b = r.scale;
    endcase
    return b;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  rec_t        hold_q, hold_d;
  logic        data_clk_q, data_clk_d;
  logic        en_q, en_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rec_ready_q, rec_ready_d;

  rec_t rec_in;
  logic accept;

  assign rec_in = {rec_id, rec_x, rec_y, rec_scale};
  assign accept = rec_valid && rec_ready_q;

  // All outputs come straight from registers, so byte, enable and strobe
  // change together on one edge and never glitch, even with CLK_DIV = 1.
  always_comb begin
    // NOTE: every _d gets its hold value first; a path that forgets to assign
    // would otherwise infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    data_clk_d = data_clk_q;
    en_d       = en_q;
    data_d     = data_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d     = rec_in;
          phase_d    = '0;
          byte_idx_d = '0;
          data_clk_d = 1'b0;
`ifdef SPRITE_TX_RESYNC_EN
          state_d    = SYNC_LOW;
          en_d       = 1'b0;
          data_d     = '0;
`else
          // Byte 0 is taken from the inputs because hold_q loads on this edge.
          state_d    = LOW;
          en_d       = 1'b1;
          data_d     = byte_sel(rec_in, 3'd0);
`endif
        end
      end

`ifdef SPRITE_TX_RESYNC_EN
      SYNC_LOW: begin
        if (phase_q == PHASE_LAST) begin
          phase_d    = '0;
          state_d    = SYNC_HIGH;
          data_clk_d = 1'b1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      SYNC_HIGH: begin
        if (phase_q == PHASE_LAST) begin
          phase_d    = '0;
          state_d    = LOW;
          data_clk_d = 1'b0;
          en_d       = 1'b1;
          data_d     = byte_sel(hold_q, 3'd0);
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
`endif

      LOW: begin
        if (phase_q == PHASE_LAST) begin
          phase_d    = '0;
          state_d    = HIGH;
          data_clk_d = 1'b1;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      HIGH: begin
        if (phase_q == PHASE_LAST) begin
          phase_d    = '0;
          data_clk_d = 1'b0;
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
            en_d    = 1'b0;
            data_d  = '0;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            // Byte/enable only ever change here, on entry to LOW, so they are
            // stable across the following data_clk rising edge.
            state_d    = LOW;
            byte_idx_d = byte_idx_q + 3'd1;
            data_d     = byte_sel(hold_q, byte_idx_q + 3'd1);
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so that it is low during reset and rises on the first edge
    // after reset release; otherwise it mirrors "in IDLE".
    rec_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the holding register is a handful of flops, not a RAM, so it is
      // cleared with everything else and a partial record leaves no trace.
      state_q     <= IDLE;
      phase_q     <= '0;
      byte_idx_q  <= '0;
      hold_q      <= '0;
      data_clk_q  <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      rec_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_idx_q  <= byte_idx_d;
      hold_q      <= hold_d;
      data_clk_q  <= data_clk_d;
      en_q        <= en_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rec_ready_q <= rec_ready_d;
    end
  end

  assign rec_ready    = rec_ready_q;
  assign data_clk     = data_clk_q;
  assign enqueue_en   = en_q;
  assign enqueue_data = data_q;
  assign busy         = (state_q != IDLE);
  assign records_sent = cnt_q;

endmodule
